// File: rtl/keypad_encoder.sv
// keypad_encoder: scans and debounces a 4x4 keypad, emitting one-cycle calculator key events.
// Define KPD_AUTOREPEAT_EN to auto-repeat held digit keys every REPEAT_CNT cycles.
module keypad_encoder #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE_CNT = 50000
`ifdef KPD_AUTOREPEAT_EN
  , parameter int REPEAT_CNT = 25000000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] rows,
  input  logic [3:0] cols,
  output logic       is_num,
  output logic       is_op,
  output logic       is_eq,
  output logic       is_clr,
  output logic [3:0] num_val,
  output logic [1:0] op_val
);
  localparam int SW = $clog2(SCAN_DIV) + 1;
  localparam int DW = $clog2(DEBOUNCE_CNT) + 1;
  localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CNT - 1);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, RELEASE} state_t;
  state_t state, state_n;
  logic [3:0] c1, col_s, dval;
  logic [1:0] r, r_n, c, c_n, pc;
  logic [SW-1:0] scan_cnt, scan_n;
  logic [DW-1:0] db_cnt, db_n;
  logic low, digit, go;
`ifdef KPD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CNT) + 1;
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CNT - 1);
  logic [RW-1:0] rep_cnt, rep_n;
`endif
  assign rows = ~(4'b0001 << r);
  assign low = ~col_s[c];
  assign pc = ~col_s[0] ? 2'd0 : ~col_s[1] ? 2'd1 : ~col_s[2] ? 2'd2 : 2'd3;
  assign digit = (r != 2'd3 && c != 2'd3) || (r == 2'd3 && c == 2'd1);
  assign dval = r == 2'd3 ? 4'd0 : 4'(r) * 4'd3 + 4'(c) + 4'd1;
  assign go = state_n == EMIT;
  always_comb begin
    state_n = state;
    r_n = r;
    c_n = c;
    scan_n = scan_cnt;
    db_n = db_cnt;
`ifdef KPD_AUTOREPEAT_EN
    rep_n = rep_cnt;
`endif
    case (state)
      SCAN: begin
        scan_n = scan_cnt == S_LAST ? '0 : scan_cnt + 1'b1;
        if (scan_cnt == S_LAST && !(&col_s)) begin
          state_n = DEBOUNCE;
          c_n = pc;
        end else if (scan_cnt == S_LAST)
          r_n = r + 2'd1;
      end
      DEBOUNCE: begin
        db_n = !low || db_cnt == D_LAST ? '0 : db_cnt + 1'b1;
        state_n = !low ? SCAN : db_cnt == D_LAST ? EMIT : DEBOUNCE;
        r_n = !low ? r + 2'd1 : r;
      end
      EMIT: begin
        state_n = RELEASE;
`ifdef KPD_AUTOREPEAT_EN
        rep_n = RW'(1);
`endif
      end
      RELEASE: begin
        db_n = low || db_cnt == D_LAST ? '0 : db_cnt + 1'b1;
        state_n = !low && db_cnt == D_LAST ? SCAN : RELEASE;
        r_n = !low && db_cnt == D_LAST ? r + 2'd1 : r;
`ifdef KPD_AUTOREPEAT_EN
        // the EMIT cycle counts toward the hold, so repeats land exactly REPEAT_CNT apart
        rep_n = !low ? '0 : rep_cnt == R_LAST ? rep_cnt : rep_cnt + 1'b1;
        if (low && digit && rep_cnt == R_LAST)
          state_n = EMIT;
`endif
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= SCAN;
      r <= '0;
      c <= '0;
      scan_cnt <= '0;
      db_cnt <= '0;
      c1 <= '1;
      col_s <= '1;
      {is_num, is_op, is_eq, is_clr} <= '0;
      num_val <= '0;
      op_val <= '0;
    end else begin
      state <= state_n;
      r <= r_n;
      c <= c_n;
      scan_cnt <= scan_n;
      db_cnt <= db_n;
      c1 <= cols;
      col_s <= c1;
      is_num <= go && digit;
      is_op <= go && c == 2'd3;
      is_eq <= go && r == 2'd3 && c == 2'd2;
      is_clr <= go && r == 2'd3 && c == 2'd0;
      num_val <= go && digit ? dval : num_val;
      op_val <= go && c == 2'd3 ? r : op_val;
    end
`ifdef KPD_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      rep_cnt <= '0;
    else
      rep_cnt <= rep_n;
`endif
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: self-checking bench for keypad_encoder with a behavioural keypad matrix.
module tb_keypad_encoder;
  localparam int SD = 4, DB = 8;
  localparam int LAT = 4 * SD + 2 + DB + 1, GAP = 2 * DB + 1;
`ifdef KPD_AUTOREPEAT_EN
  localparam int RP = 40;
`endif
  typedef struct { logic [15:0] keys; int kind; int val; int num; int op; } vec_t;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] rows, cols, num_val;
  logic is_num, is_op, is_eq, is_clr;
  logic [1:0] op_val;
  logic [15:0] keys = '0;
  int n_chk = 0, n_fail = 0, cyc = 0, npulse = 0;
  int ptimes[$], pvals[$], pkinds[$];
  string kmap = "123+456-789*C0=/";
  vec_t tbl [12];

  keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)
`ifdef KPD_AUTOREPEAT_EN
    , .REPEAT_CNT(RP)
`endif
  ) dut (.clk(clk), .reset(reset), .rows(rows), .cols(cols), .is_num(is_num), .is_op(is_op),
         .is_eq(is_eq), .is_clr(is_clr), .num_val(num_val), .op_val(op_val));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // keypad matrix: a pressed key pulls its column low while its row is driven low
  always_comb begin
    cols = 4'hf;
    for (int cc = 0; cc < 4; cc++)
      for (int rr = 0; rr < 4; rr++)
        if (keys[rr*4+cc] && !rows[rr]) cols[cc] = 1'b0;
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) if (reset) begin
    cmp("pulse_onehot", int'($countones({is_num, is_op, is_eq, is_clr}) <= 1), 1);
    cmp("rows_one_low", $countones(~rows), 1);
    if (is_num || is_op || is_eq || is_clr) begin
      if (npulse > 0) cmp("pulse_gap", int'(cyc - ptimes[$] >= GAP), 1);
      npulse++;
      ptimes.push_back(cyc);
      pkinds.push_back(is_num ? 0 : is_op ? 1 : is_eq ? 2 : 3);
      pvals.push_back(is_num ? int'(num_val) : is_op ? int'(op_val) : 0);
    end
  end

  function automatic void model(input int idx, output int kind, output int val);
    byte ch;
    ch = kmap[idx];
    kind = 1;
    val = 0;
    if (ch >= "0" && ch <= "9") begin kind = 0; val = ch - "0"; end
    else if (ch == "=") kind = 2;
    else if (ch == "C") kind = 3;
    else val = ch == "+" ? 0 : ch == "-" ? 1 : ch == "*" ? 2 : 3;
  endfunction

  task automatic wait_pulse(input string name, input int n0, input int bound);
    int k;
    k = 0;
    while (npulse == n0 && k < bound) begin @(negedge clk); k++; end
    cmp(name, int'(npulse > n0), 1);
  endtask

  task automatic do_press(input logic [15:0] k, input int hold, input int rel, output int cnt);
    int n0;
    n0 = npulse;
    @(posedge clk); #1 keys = k;
    repeat (hold) @(posedge clk);
    #1 keys = '0;
    repeat (rel) @(posedge clk);
    #1 cnt = npulse - n0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, c0, cnt, k, bad, ek, ev, mnum, mop, rr, ca, cb;
    logic [15:0] kv;
    tbl[0]  = '{16'h0001, 0, 1, 1, 0};
    tbl[1]  = '{16'h0080, 1, 1, 1, 1};
    tbl[2]  = '{16'h0400, 0, 9, 9, 1};
    tbl[3]  = '{16'h0800, 1, 2, 9, 2};
    tbl[4]  = '{16'h2000, 0, 0, 0, 2};
    tbl[5]  = '{16'h8000, 1, 3, 0, 3};
    tbl[6]  = '{16'hC000, 2, 0, 0, 3};
    tbl[7]  = '{16'h1000, 3, 0, 0, 3};
    tbl[8]  = '{16'h00C0, 0, 6, 6, 3};
    tbl[9]  = '{16'h0200, 0, 8, 8, 3};
    tbl[10] = '{16'h0004, 0, 3, 3, 3};
    tbl[11] = '{16'h0010, 0, 4, 4, 3};
    // reset and idle scan
    repeat (3) @(posedge clk);
    @(negedge clk);
    cmp("rst_rows", rows, 4'b1110);
    cmp("rst_pulses", {is_num, is_op, is_eq, is_clr}, 0);
    cmp("rst_num_val", num_val, 0);
    cmp("rst_op_val", op_val, 0);
    @(posedge clk); #1 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cmp("idle_rows", rows, 15 ^ (1 << ((i / 4) % 4)));
    end
    cmp("idle_no_pulse", npulse, 0);
    cmp("idle_num_val", num_val, 0);
    cmp("idle_op_val", op_val, 0);
    // digit '5': latency, single pulse, row frozen through release debounce
    n0 = npulse;
    @(posedge clk); #1 keys = 16'h0020;
    c0 = cyc;
    wait_pulse("d5_seen", n0, LAT + 5);
    if (npulse > n0) begin
      cmp("d5_latency_ok", int'(ptimes[n0] - c0 <= LAT), 1);
      cmp("d5_kind", pkinds[n0], 0);
      cmp("d5_val", pvals[n0], 5);
    end
    bad = 0;
    while (cyc - c0 < 100) begin @(negedge clk); if (rows != 4'b1101) bad++; end
    cmp("d5_hold_frozen", bad, 0);
    @(posedge clk); #1 keys = '0;
    for (int i = 0; i < 8; i++) begin @(negedge clk); cmp("d5_rel_frozen", rows, 4'b1101); end
    k = 0;
    while (rows != 4'b1011 && k < 6) begin @(negedge clk); k++; end
    cmp("d5_rel_advance", rows, 4'b1011);
`ifdef KPD_AUTOREPEAT_EN
    cmp("d5_count", int'(npulse - n0 >= 1), 1);
`else
    cmp("d5_count", npulse - n0, 1);
`endif
    repeat (10) @(posedge clk);
    // bouncing '+' is rejected, then a clean hold is accepted
    n0 = npulse;
    for (int i = 0; i < 30; i++) begin @(posedge clk); #1 keys = ((i / 3) % 2 == 0) ? 16'h0008 : 16'h0000; end
    repeat (12) @(posedge clk);
    cmp("bounce_none", npulse, n0);
    do_press(16'h0008, 45, 20, cnt);
    cmp("bounce_follow_count", cnt, 1);
    cmp("bounce_follow_kind", pkinds[$], 1);
    cmp("bounce_follow_op_val", op_val, 0);
    // key map vectors, including same-row pairs
    for (int i = 0; i < 12; i++) begin
      do_press(tbl[i].keys, 45, 20, cnt);
      cmp($sformatf("vec%0d_count", i), cnt, 1);
      cmp($sformatf("vec%0d_kind", i), pkinds[$], tbl[i].kind);
      cmp($sformatf("vec%0d_val", i), pvals[$], tbl[i].val);
      cmp($sformatf("vec%0d_num_val", i), num_val, tbl[i].num);
      cmp($sformatf("vec%0d_op_val", i), op_val, tbl[i].op);
    end
    // reset while '9' is being debounced
    n0 = npulse;
    k = 0;
    while (rows != 4'b1101 && k < 20) begin @(negedge clk); k++; end
    cmp("mid_row1_seen", rows, 4'b1101);
    keys = 16'h0400;
    k = 0;
    while (rows != 4'b1011 && k < 20) begin @(negedge clk); k++; end
    repeat (6) @(negedge clk);
    cmp("mid_captured_row", rows, 4'b1011);
    reset = 1'b0;
    #1;
    cmp("mid_rst_rows", rows, 4'b1110);
    cmp("mid_rst_num_val", num_val, 0);
    cmp("mid_rst_op_val", op_val, 0);
    cmp("mid_rst_pulses", {is_num, is_op, is_eq, is_clr}, 0);
    cmp("mid_no_pulse", npulse, n0);
    repeat (3) @(posedge clk);
    @(posedge clk); #1 reset = 1'b1;
    c0 = cyc;
    wait_pulse("mid_seen", n0, LAT + 5);
    if (npulse > n0) begin
      cmp("mid_latency_ok", int'(ptimes[n0] - c0 <= LAT), 1);
      cmp("mid_kind", pkinds[n0], 0);
      cmp("mid_val", pvals[n0], 9);
    end
    keys = '0;
    repeat (20) @(posedge clk);
    cmp("mid_count", npulse - n0, 1);
    // long hold of '7' (digit) and '*' (operator)
    n0 = npulse;
    @(posedge clk); #1 keys = 16'h0100;
    c0 = cyc;
    repeat (150) @(posedge clk);
    #1 keys = '0;
    repeat (25) @(posedge clk);
    cnt = npulse - n0;
`ifdef KPD_AUTOREPEAT_EN
    if (cnt >= 1) begin
      cmp("rep7_count", cnt, 1 + (150 - (ptimes[n0] - c0)) / RP);
      for (int i = 1; i < cnt; i++) cmp("rep7_interval", ptimes[n0+i] - ptimes[n0+i-1], RP);
    end else cmp("rep7_count", cnt, 1);
`else
    cmp("rep7_count", cnt, 1);
`endif
    for (int i = 0; i < cnt; i++) cmp("rep7_val", pvals[n0+i], 7);
    do_press(16'h0800, 150, 25, cnt);
    cmp("rep_star_count", cnt, 1);
    cmp("rep_star_op_val", op_val, 2);
    // randomized presses against the key-map model
    mnum = 7;
    mop = 2;
    for (int i = 0; i < 10; i++) begin
      rr = $urandom_range(0, 3);
      ca = $urandom_range(0, 3);
      cb = $urandom_range(0, 3);
      kv = '0;
      kv[rr*4+ca] = 1'b1;
      if ($urandom_range(0, 1) == 1) kv[rr*4+cb] = 1'b1;
      else cb = ca;
      model(rr * 4 + (ca < cb ? ca : cb), ek, ev);
      if (ek == 0) mnum = ev;
      if (ek == 1) mop = ev;
      do_press(kv, $urandom_range(35, 45), 20, cnt);
      cmp($sformatf("rnd%0d_count", i), cnt, 1);
      cmp($sformatf("rnd%0d_kind", i), pkinds[$], ek);
      cmp($sformatf("rnd%0d_val", i), pvals[$], ev);
      cmp($sformatf("rnd%0d_num_val", i), num_val, mnum);
      cmp($sformatf("rnd%0d_op_val", i), op_val, mop);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
